// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches it drives.
// Holds the state encoding, default geometry and a counter-width helper.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned PatWDefault   = 3;
    localparam int unsigned RepWDefault   = 4;
    localparam int unsigned GapLenDefault = 1;

    // Width of a down-counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_piso_shreg.sv
// Parallel-in serial-out shift register: load has priority over shift, zero-fill on shift left.
// Only the MSB is exposed; it is the next serial bit.
module piso_shreg #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= din;
        end else if (shift) begin
            shreg_q <= {shreg_q[W-2:0], 1'b0};
        end
    end

    assign msb = shreg_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated reps times with an
// optional idle gap between repetitions, then pulses done for one cycle.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W   = PatWDefault,
    parameter int unsigned REP_W   = RepWDefault,
    parameter int unsigned GAP_LEN = GapLenDefault
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = cnt_width(PAT_W);
    localparam int unsigned GapW = cnt_width(GAP_LEN);
    localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [GapW-1:0]  gap_q, gap_d;

    logic             sh_load, sh_shift, sh_msb;
    logic [PAT_W-1:0] sh_din;

    piso_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .clr   (clr),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rep_d    = rep_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = hold_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hold_d  = pat_in;
                    rep_d   = reps;
                    bit_d   = BitLast;
                    sh_load = 1'b1;
                    sh_din  = pat_in;
                    state_d = (reps != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (bit_q != '0) begin
                    bit_d    = bit_q - BitW'(1);
                    sh_shift = 1'b1;
                end else if (rep_q == REP_W'(1)) begin
                    sh_shift = 1'b1;
                    state_d  = StDone;
                end else begin
                    // Reload in the last-bit cycle so back-to-back repetitions have no bubble.
                    rep_d   = rep_q - REP_W'(1);
                    bit_d   = BitLast;
                    sh_load = 1'b1;
                    if (GAP_LEN > 0) begin
                        gap_d   = GapLast;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StShift;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StDone: begin
                rep_d   = '0;
                bit_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            hold_q  <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign valid = (state_q == StShift);
    assign out   = valid & sh_msb;
    assign busy  = (state_q == StShift) || (state_q == StGap);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench: stimulus queues the expected {out,valid,busy,done} per cycle; a monitor
// compares on each falling edge. Two instances cover GAP_LEN=1 and back-to-back GAP_LEN=0.
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] S1 = 4'b1110;
    localparam logic [3:0] S0 = 4'b0110;
    localparam logic [3:0] G  = 4'b0010;
    localparam logic [3:0] D  = 4'b0001;

    logic       clk = 1'b0;
    logic       clr;
    logic       start0, start1;
    logic [2:0] pat0, pat1;
    logic [3:0] reps0, reps1;
    logic       out0, valid0, busy0, done0;
    logic       out1, valid1, busy1, done1;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int idx0     = 0;
    int idx1     = 0;
    int hits     = 0;
    int exp_hits = 0;
    int hits_at_start = 0;
    logic hits_req = 1'b0, hits_checked = 1'b0;
    logic final_req = 1'b0, final_checked = 1'b0;
    logic [2:0] hist = 3'b000;

    always #5 clk = ~clk;

    seq_pattern_tx #(
        .PAT_W   (PatWDefault),
        .REP_W   (RepWDefault),
        .GAP_LEN (1)
    ) dut0 (
        .clk    (clk),
        .clr    (clr),
        .start  (start0),
        .pat_in (pat0),
        .reps   (reps0),
        .out    (out0),
        .valid  (valid0),
        .busy   (busy0),
        .done   (done0)
    );

    seq_pattern_tx #(
        .PAT_W   (PatWDefault),
        .REP_W   (RepWDefault),
        .GAP_LEN (0)
    ) dut1 (
        .clk    (clk),
        .clr    (clr),
        .start  (start1),
        .pat_in (pat1),
        .reps   (reps1),
        .out    (out1),
        .valid  (valid1),
        .busy   (busy1),
        .done   (done1)
    );

    // Overlapping 101 detector on the back-to-back stream.
    always @(posedge clk) begin
        if (clr) begin
            hist <= 3'b000;
        end else if (valid1) begin
            hist <= {hist[1:0], out1};
            if ({hist[1:0], out1} == 3'b101) hits <= hits + 1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [3:0] exp, act;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                exp = q0.pop_front();
                act = {out0, valid0, busy0, done0};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL gap1_trace[%0d]: out/valid/busy/done got %b expected %b",
                             idx0, act, exp);
                end
                idx0++;
            end
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                act = {out1, valid1, busy1, done1};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL gap0_trace[%0d]: out/valid/busy/done got %b expected %b",
                             idx1, act, exp);
                end
                idx1++;
            end
            if (hits_req && !hits_checked) begin
                hits_checked = 1'b1;
                n_checks++;
                if (hits - hits_at_start != exp_hits) begin
                    n_fail++;
                    $display("FAIL detector_hits: got %0d expected %0d",
                             hits - hits_at_start, exp_hits);
                end
            end
            if (final_req && !final_checked) begin
                final_checked = 1'b1;
                n_checks++;
                if (q0.size() != 0 || q1.size() != 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_drain: left %0d/%0d expected 0/0",
                             q0.size(), q1.size());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic [3:0] v);
        q0.push_back(v);
    endtask

    task automatic p1(input logic [3:0] v);
        q1.push_back(v);
    endtask

    initial begin
        logic [8:0] exp_bits;
        clr = 1'b1; start0 = 1'b0; start1 = 1'b0;
        pat0 = '0; pat1 = '0; reps0 = '0; reps1 = '0;
        repeat (3) step();

        // Reset state, then release.
        p0(Z); p1(Z); step();
        clr = 1'b0;
        p0(Z); p1(Z); step();

        // Basic: 101, reps=1.
        start0 = 1'b1; pat0 = 3'b101; reps0 = 4'd1;
        p0(Z); p0(S1); p0(S0); p0(S1); p0(D); p0(Z);
        step(); start0 = 1'b0; pat0 = 3'b000;
        repeat (5) step();

        // Repeat with one-cycle gap: 101, reps=2.
        start0 = 1'b1; pat0 = 3'b101; reps0 = 4'd2;
        p0(Z); p0(S1); p0(S0); p0(S1); p0(G); p0(S1); p0(S0); p0(S1); p0(D); p0(Z);
        step(); start0 = 1'b0; reps0 = 4'd9;
        repeat (9) step();

        // reps=0: straight to done, no bits.
        start0 = 1'b1; pat0 = 3'b111; reps0 = 4'd0;
        p0(Z); p0(D); p0(Z);
        step(); start0 = 1'b0;
        repeat (2) step();

        // Reset during the second bit of a 3-rep transmission.
        start0 = 1'b1; pat0 = 3'b101; reps0 = 4'd3;
        p0(Z); p0(S1); p0(S0);
        repeat (6) p0(Z);
        step(); start0 = 1'b0;
        step(); clr = 1'b1;
        step(); clr = 1'b0;
        repeat (6) step();

        // clr and start at the same edge: clr wins.
        clr = 1'b1; start0 = 1'b1; pat0 = 3'b101; reps0 = 4'd1;
        p0(Z); p0(Z); p0(Z);
        step(); clr = 1'b0; start0 = 1'b0;
        repeat (2) step();

        // start held high; pat_in changes mid-shift only affect the next capture.
        start0 = 1'b1; pat0 = 3'b101; reps0 = 4'd1;
        p0(Z); p0(S1); p0(S0); p0(S1); p0(D); p0(Z);
        p0(S0); p0(S1); p0(S1); p0(D); p0(Z);
        step();
        step(); pat0 = 3'b011;
        repeat (7) step();
        start0 = 1'b0;
        repeat (2) step();

        // Back-to-back into the 101 detector: 101 x3.
        exp_bits = 9'b101_101_101;
        exp_hits = 0;
        for (int j = 0; j <= 6; j++) begin
            if ({exp_bits[j+2], exp_bits[j+1], exp_bits[j]} == 3'b101) exp_hits++;
        end
        hits_at_start = hits;
        start1 = 1'b1; pat1 = 3'b101; reps1 = 4'd3;
        p1(Z);
        for (int j = 8; j >= 0; j--) p1(exp_bits[j] ? S1 : S0);
        p1(D); p1(Z);
        step(); start1 = 1'b0; pat1 = 3'b000; reps1 = 4'd0;
        repeat (11) step();
        hits_req = 1'b1;
        step();
        final_req = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
